// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory arbiter: write sizes, requester IDs, FSM states.
package mem_pkg;
  localparam logic [1:0] WSIZE_NONE = 2'b00;
  localparam logic [1:0] WSIZE_B    = 2'b01;
  localparam logic [1:0] WSIZE_H    = 2'b10;
  localparam logic [1:0] WSIZE_W    = 2'b11;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select. MEM_ARB_RR_EN selects round-robin on `last`;
// otherwise DBG wins ties unless the CPU has been starved.
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic cpu_req,
  input  logic dbg_req,
`ifdef MEM_ARB_RR_EN
  input  logic last,
`else
  input  logic starved,
`endif
  output logic winner
);
  always_comb begin
    winner = REQ_CPU;
    if (dbg_req && !cpu_req) begin
      winner = REQ_DBG;
    end else if (dbg_req && cpu_req) begin
`ifdef MEM_ARB_RR_EN
      winner = (last == REQ_CPU) ? REQ_DBG : REQ_CPU;
`else
      winner = starved ? REQ_CPU : REQ_DBG;
`endif
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DBG) arbiter for the single-port data memory: IDLE -> ACCESS -> RESP.
// Define MEM_ARB_RR_EN for round-robin; default is fixed priority with a starvation counter.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [1:0]            i_cpu_wsize,
  input  logic [31:0]           i_cpu_wdata,
  output logic                  o_cpu_ack,
  output logic [31:0]           o_cpu_rdata,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  input  logic [1:0]            i_dbg_wsize,
  input  logic [31:0]           i_dbg_wdata,
  output logic                  o_dbg_ack,
  output logic [31:0]           o_dbg_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_din,
  output logic [1:0]            o_mem_wsize,
  output logic                  o_mem_wen,
  output logic                  o_mem_ren,
  input  logic [31:0]           i_mem_dout,
  output logic                  o_busy
);
  logic [1:0]            state;
  logic                  owner, winner, grant;
  logic                  cpu_ack, dbg_ack;
  logic [31:0]           cpu_rdata_q, dbg_rdata_q;
  logic                  own_we;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [1:0]            own_wsize;
  logic [31:0]           own_wdata;

  assign grant = (state == ST_IDLE) && (i_cpu_req || i_dbg_req);

`ifdef MEM_ARB_RR_EN
  logic last;
  always_ff @(posedge clk) begin
    if (i_rst)      last <= REQ_DBG;
    else if (grant) last <= winner;
  end

  mem_arb_pick u_pick (
    .cpu_req (i_cpu_req),
    .dbg_req (i_dbg_req),
    .last    (last),
    .winner  (winner)
  );
`else
  logic [3:0] starve_cnt;
  logic       starved;
  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

  // Counts DBG grants that bypassed a pending CPU; held at the limit until the CPU wins.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      starve_cnt <= 4'd0;
    end else if (grant) begin
      if (winner == REQ_CPU)            starve_cnt <= 4'd0;
      else if (i_cpu_req && !starved)   starve_cnt <= starve_cnt + 4'd1;
    end
  end

  mem_arb_pick u_pick (
    .cpu_req (i_cpu_req),
    .dbg_req (i_dbg_req),
    .starved (starved),
    .winner  (winner)
  );
`endif

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      owner       <= REQ_CPU;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
      cpu_rdata_q <= 32'd0;
      dbg_rdata_q <= 32'd0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        ST_IDLE: if (grant) begin
          owner <= winner;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          state   <= ST_RESP;
          cpu_ack <= (owner == REQ_CPU);
          dbg_ack <= (owner == REQ_DBG);
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (!own_we) begin
            if (owner == REQ_CPU) cpu_rdata_q <= i_mem_dout;
            else                  dbg_rdata_q <= i_mem_dout;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign own_we    = (owner == REQ_DBG) ? i_dbg_we    : i_cpu_we;
  assign own_addr  = (owner == REQ_DBG) ? i_dbg_addr  : i_cpu_addr;
  assign own_wsize = (owner == REQ_DBG) ? i_dbg_wsize : i_cpu_wsize;
  assign own_wdata = (owner == REQ_DBG) ? i_dbg_wdata : i_cpu_wdata;

  always_comb begin
    o_mem_addr  = '0;
    o_mem_din   = 32'd0;
    o_mem_wsize = WSIZE_NONE;
    o_mem_wen   = 1'b0;
    o_mem_ren   = 1'b0;
    if (state == ST_ACCESS) begin
      o_mem_addr  = own_addr;
      o_mem_din   = own_wdata;
      o_mem_wsize = own_wsize;
      o_mem_wen   = own_we && (own_wsize != WSIZE_NONE);
      o_mem_ren   = !own_we;
    end
  end

  // Memory dout is only valid during RESP, so it is forwarded on the ack cycle and held afterwards.
  assign o_cpu_ack   = cpu_ack;
  assign o_dbg_ack   = dbg_ack;
  assign o_cpu_rdata = (cpu_ack && !i_cpu_we) ? i_mem_dout : cpu_rdata_q;
  assign o_dbg_rdata = (dbg_ack && !i_dbg_we) ? i_mem_dout : dbg_rdata_q;
  assign o_busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed memory model (registered read).
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [9:0]  cpu_addr, dbg_addr, mem_addr;
  logic [1:0]  cpu_wsize, dbg_wsize, mem_wsize;
  logic [31:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_din, mem_dout;
  logic        cpu_ack, dbg_ack, mem_wen, mem_ren, busy;

  int passed = 0;
  int total  = 0;
  int both_strobe = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(10), .STARVE_LIMIT(4)) dut (
    .clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wsize(cpu_wsize),
    .i_cpu_wdata(cpu_wdata), .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wsize(dbg_wsize),
    .i_dbg_wdata(dbg_wdata), .o_dbg_ack(dbg_ack), .o_dbg_rdata(dbg_rdata),
    .o_mem_addr(mem_addr), .o_mem_din(mem_din), .o_mem_wsize(mem_wsize),
    .o_mem_wen(mem_wen), .o_mem_ren(mem_ren), .i_mem_dout(mem_dout), .o_busy(busy)
  );

  logic [7:0] mem [0:1023];
  logic [9:0] a1, a2, a3;
  assign a1 = mem_addr + 10'd1;
  assign a2 = mem_addr + 10'd2;
  assign a3 = mem_addr + 10'd3;

  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_addr] <= mem_din[7:0];
      if (mem_wsize != 2'b01) mem[a1] <= mem_din[15:8];
      if (mem_wsize == 2'b11) begin
        mem[a2] <= mem_din[23:16];
        mem[a3] <= mem_din[31:24];
      end
    end
    if (mem_ren) mem_dout <= {mem[a3], mem[a2], mem[a1], mem[mem_addr]};
  end

  always @(negedge clk) if (mem_wen && mem_ren) both_strobe++;

  task automatic txn(input bit dbg, input bit we, input logic [9:0] addr, input logic [1:0] ws,
                     input logic [31:0] wd, output int lat, output logic [31:0] rd,
                     output bit saw_wen, output bit saw_ren, output logic [9:0] saw_addr);
    bit got = 0;
    lat = 0; rd = '0; saw_wen = 0; saw_ren = 0; saw_addr = '0;
    @(negedge clk);
    if (dbg) begin
      dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wsize = ws; dbg_wdata = wd;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wsize = ws; cpu_wdata = wd;
    end
    while (!got && lat < 8) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (mem_wen) saw_wen = 1;
      if (mem_ren) saw_ren = 1;
      if (mem_wen || mem_ren) saw_addr = mem_addr;
      if (dbg ? dbg_ack : cpu_ack) begin
        got = 1;
        rd = dbg ? dbg_rdata : cpu_rdata;
      end
    end
    cpu_req = 0; dbg_req = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wsize = 0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wsize = 0; dbg_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if ({cpu_ack, dbg_ack} !== 2'b00) $display("FAIL reset_ack got %b want 00", {cpu_ack, dbg_ack}); else passed++;
    total++; if (cpu_rdata !== 32'd0) $display("FAIL reset_cpu_rdata got %h want 0", cpu_rdata); else passed++;
    total++; if (dbg_rdata !== 32'd0) $display("FAIL reset_dbg_rdata got %h want 0", dbg_rdata); else passed++;
    total++; if ({mem_wen, mem_ren} !== 2'b00) $display("FAIL reset_strobes got %b want 00", {mem_wen, mem_ren}); else passed++;
    total++; if ({mem_addr, mem_din, mem_wsize} !== 44'd0) $display("FAIL reset_mem_bus got %h want 0", {mem_addr, mem_din, mem_wsize}); else passed++;
    rst = 0;
  endtask

  task automatic test_cpu_only();
    int lat; logic [31:0] rd; bit sw, sr; logic [9:0] sa;
    txn(0, 1, 10'h010, 2'b11, 32'hDEADBEEF, lat, rd, sw, sr, sa);
    total++; if (lat !== 2) $display("FAIL cpu_wr_latency got %0d want 2", lat); else passed++;
    total++; if ({sw, sr} !== 2'b10) $display("FAIL cpu_wr_strobes got %b want 10", {sw, sr}); else passed++;
    total++; if (sa !== 10'h010) $display("FAIL cpu_wr_addr got %h want 010", sa); else passed++;
    txn(0, 0, 10'h010, 2'b00, 32'd0, lat, rd, sw, sr, sa);
    total++; if (lat !== 2) $display("FAIL cpu_rd_latency got %0d want 2", lat); else passed++;
    total++; if ({sw, sr} !== 2'b01) $display("FAIL cpu_rd_strobes got %b want 01", {sw, sr}); else passed++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL cpu_rd_data got %h want deadbeef", rd); else passed++;
  endtask

  task automatic test_dbg_only();
    int lat; logic [31:0] rd; bit sw, sr; logic [9:0] sa;
    txn(1, 1, 10'h021, 2'b01, 32'h000000AA, lat, rd, sw, sr, sa);
    total++; if (lat !== 2) $display("FAIL dbg_sb_latency got %0d want 2", lat); else passed++;
    txn(1, 1, 10'h022, 2'b10, 32'h00001234, lat, rd, sw, sr, sa);
    total++; if (lat !== 2) $display("FAIL dbg_sh_latency got %0d want 2", lat); else passed++;
    txn(1, 0, 10'h020, 2'b00, 32'd0, lat, rd, sw, sr, sa);
    total++; if (lat !== 2) $display("FAIL dbg_rd_latency got %0d want 2", lat); else passed++;
    total++; if (rd !== 32'h1234AA00) $display("FAIL dbg_rd_data got %h want 1234aa00", rd); else passed++;
  endtask

  // Both requesters held high; records which side is acked for ten transactions.
  task automatic run_contention(output logic [9:0] who, output int gap_bad, output int first_cyc);
    int cyc = 0, prev = 0, w;
    who = '0; gap_bad = 0; first_cyc = -1;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'h000;
    dbg_req = 1; dbg_we = 0; dbg_addr = 10'h004;
    for (int k = 0; k < 10; k++) begin
      w = 0;
      do begin
        @(posedge clk); @(negedge clk);
        cyc++; w++;
      end while (!(cpu_ack || dbg_ack) && w < 8);
      if (cpu_ack && dbg_ack) gap_bad++;
      if (!(cpu_ack || dbg_ack)) gap_bad++;
      who[k] = dbg_ack;
      if (k == 0) first_cyc = cyc;
      else if (cyc - prev != 3) gap_bad++;
      prev = cyc;
    end
    cpu_req = 0; dbg_req = 0;
  endtask

`ifdef MEM_ARB_RR_EN
  task automatic test_round_robin();
    logic [9:0] who; int gap_bad, first_cyc;
    run_contention(who, gap_bad, first_cyc);
    total++; if (who !== 10'b1010101010) $display("FAIL rr_order got %b want 1010101010", who); else passed++;
    total++; if (gap_bad !== 0) $display("FAIL rr_spacing got %0d bad want 0", gap_bad); else passed++;
    total++; if (first_cyc !== 2) $display("FAIL rr_first_latency got %0d want 2", first_cyc); else passed++;
  endtask
`else
  task automatic test_fixed_priority();
    logic [9:0] who; int gap_bad, first_cyc;
    run_contention(who, gap_bad, first_cyc);
    total++; if (who !== 10'b0111101111) $display("FAIL fixed_order got %b want 0111101111", who); else passed++;
    total++; if (gap_bad !== 0) $display("FAIL fixed_spacing got %0d bad want 0", gap_bad); else passed++;
    total++; if (first_cyc !== 2) $display("FAIL fixed_first_latency got %0d want 2", first_cyc); else passed++;
  endtask
`endif

  task automatic test_reset_mid_access();
    int acks = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h100; cpu_wsize = 2'b11; cpu_wdata = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    total++; if ({busy, mem_wen} !== 2'b11) $display("FAIL midrst_in_access got %b want 11", {busy, mem_wen}); else passed++;
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0; cpu_req = 0;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
    total++; if ({mem_wen, mem_ren} !== 2'b00) $display("FAIL midrst_strobes got %b want 00", {mem_wen, mem_ren}); else passed++;
    if (cpu_ack) acks++;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (cpu_ack || dbg_ack) acks++;
    end
    total++; if (acks !== 0) $display("FAIL midrst_ack got %0d acks want 0", acks); else passed++;
  endtask

  task automatic test_wsize_none();
    int lat; logic [31:0] rd; bit sw, sr; logic [9:0] sa;
    txn(0, 1, 10'h040, 2'b00, 32'h11111111, lat, rd, sw, sr, sa);
    total++; if (lat !== 2) $display("FAIL wsize0_latency got %0d want 2", lat); else passed++;
    total++; if ({sw, sr} !== 2'b00) $display("FAIL wsize0_strobes got %b want 00", {sw, sr}); else passed++;
    txn(1, 0, 10'h040, 2'b00, 32'd0, lat, rd, sw, sr, sa);
    total++; if (rd !== 32'd0) $display("FAIL wsize0_mem_untouched got %h want 0", rd); else passed++;
    total++; if (both_strobe !== 0) $display("FAIL wen_ren_both got %0d cycles want 0", both_strobe); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem_dout = 32'd0;
    test_reset();
    test_cpu_only();
    test_dbg_only();
`ifdef MEM_ARB_RR_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_reset_mid_access();
    test_wsize_none();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
